// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad entry block.
package keypad_pkg;

  localparam int CODE_W = 4;

  // Encoder output when no line is asserted; validity is tracked separately.
  localparam logic [CODE_W-1:0] NO_KEY = '0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESS,
    ST_HELD,
    ST_RELEASE
  } kp_state_e;

endpackage

// File: rtl/keypad_debounce.sv
// Priority encoder plus press/release debounce FSM; emits a one-cycle accept with code.
// Optional auto-repeat while held is enabled by defining KEYPAD_AUTOREPEAT_EN.
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int N_KEYS          = 10,
  parameter int DEBOUNCE_CYCLES = 7,
  parameter int REPEAT_CYCLES   = 50
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic [N_KEYS-1:0] i_keypad,
  output logic              o_accept,
  output logic [CODE_W-1:0] o_code
);

  localparam logic [7:0] DB_LAST = 8'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 255) begin : g_bad_db
    $error("keypad_debounce: DEBOUNCE_CYCLES out of range");
  end
  if (REPEAT_CYCLES < 1) begin : g_bad_rpt
    $error("keypad_debounce: REPEAT_CYCLES must be positive");
  end

  kp_state_e         r_state;
  logic [7:0]        r_cnt;
  logic [CODE_W-1:0] r_cand;
  logic [CODE_W-1:0] w_code;
  logic              w_any;
  logic              w_match;
  logic              w_press_acc;

  // Ascending scan so the highest asserted index is the last assignment.
  always_comb begin
    w_code = NO_KEY;
    for (int i = 0; i < N_KEYS; i++) begin
      if (i_keypad[i]) w_code = CODE_W'(i);
    end
  end

  assign w_any       = |i_keypad;
  assign w_match     = w_any && (w_code == r_cand);
  assign w_press_acc = i_en && (r_state == ST_PRESS) && w_match && (r_cnt == DB_LAST);
  assign o_code      = r_cand;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int             RPT_W    = $clog2(REPEAT_CYCLES + 1);
  localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);

  logic [RPT_W-1:0] r_rpt;
  logic             w_rpt_acc;

  assign w_rpt_acc = i_en && (r_state == ST_HELD) && w_match && (r_rpt == RPT_LAST);
  assign o_accept  = w_press_acc || w_rpt_acc;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rpt <= '0;
    end else if (i_en && (r_state == ST_HELD) && w_match) begin
      r_rpt <= w_rpt_acc ? '0 : r_rpt + RPT_W'(1);
    end else begin
      r_rpt <= '0;
    end
  end
`else
  assign o_accept = w_press_acc;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_cand  <= NO_KEY;
    end else if (!i_en) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          if (w_any) begin
            r_state <= ST_PRESS;
            r_cand  <= w_code;
          end
        end
        ST_PRESS: begin
          if (!w_match) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end else if (r_cnt == DB_LAST) begin
            r_state <= ST_HELD;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        ST_HELD: begin
          r_cnt <= '0;
          if (!w_any) r_state <= ST_RELEASE;
        end
        ST_RELEASE: begin
          // Any line bouncing back, even a different key, returns to HELD without acceptance.
          if (w_any) begin
            r_state <= ST_HELD;
            r_cnt   <= '0;
          end else if (r_cnt == DB_LAST) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/keypad_entry.sv
// Keypad entry: debounced key capture into a BCD shift buffer with load/overflow strobes.
// Optional auto-repeat via KEYPAD_AUTOREPEAT_EN (handled in keypad_debounce).
module keypad_entry
  import keypad_pkg::*;
#(
  parameter int N_KEYS          = 10,
  parameter int DIGITS          = 4,
  parameter int DEBOUNCE_CYCLES = 7,
  parameter int REPEAT_CYCLES   = 50,
  localparam int CNT_W          = $clog2(DIGITS + 1)
) (
  input  logic                  clk,
  input  logic                  clear,
  input  logic                  enablen,
  input  logic [N_KEYS-1:0]     keypad,
  input  logic                  clr_entry,
  output logic [CODE_W-1:0]     D,
  output logic [4*DIGITS-1:0]   digits,
  output logic [CNT_W-1:0]      count,
  output logic                  loadn,
  output logic                  full,
  output logic                  overflow
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIGITS);

  if (N_KEYS < 2 || N_KEYS > 16) begin : g_bad_nkeys
    $error("keypad_entry: N_KEYS out of range");
  end
  if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
    $error("keypad_entry: DIGITS out of range");
  end

  logic [CODE_W-1:0]   r_D;
  logic [4*DIGITS-1:0] r_digits;
  logic [CNT_W-1:0]    r_count;
  logic                r_loadn;
  logic                r_overflow;
  logic                w_accept;
  logic [CODE_W-1:0]   w_code;
  logic                w_full;
  logic [4*DIGITS-1:0] w_shift;

  keypad_debounce #(
    .N_KEYS          (N_KEYS),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .REPEAT_CYCLES   (REPEAT_CYCLES)
  ) u_debounce (
    .i_clk    (clk),
    .i_rst    (clear),
    .i_en     (!enablen),
    .i_keypad (keypad),
    .o_accept (w_accept),
    .o_code   (w_code)
  );

  if (DIGITS == 1) begin : g_shift1
    assign w_shift = w_code;
  end else begin : g_shiftn
    assign w_shift = {r_digits[4*DIGITS-5:0], w_code};
  end

  assign w_full = (r_count == CNT_MAX);

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      r_D        <= NO_KEY;
      r_digits   <= '0;
      r_count    <= '0;
      r_loadn    <= 1'b1;
      r_overflow <= 1'b0;
    end else begin
      r_loadn    <= 1'b1;
      r_overflow <= 1'b0;
      // A buffer clear discards any key accepted on the same edge.
      if (clr_entry) begin
        r_digits <= '0;
        r_count  <= '0;
      end else if (w_accept) begin
        if (w_full) begin
          r_overflow <= 1'b1;
        end else begin
          r_digits <= w_shift;
          r_count  <= r_count + CNT_W'(1);
          r_D      <= w_code;
          r_loadn  <= 1'b0;
        end
      end
    end
  end

  assign D        = r_D;
  assign digits   = r_digits;
  assign count    = r_count;
  assign loadn    = r_loadn;
  assign full     = w_full;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_keypad_entry.sv
// Directed bench for keypad_entry (default parameters; KEYPAD_AUTOREPEAT_EN selects the repeat scenario).
module tb_keypad_entry;

  localparam int N_KEYS = 10;
  localparam int DIGITS = 4;
  localparam int DB     = 7;
  localparam int RPT    = 50;
  localparam int CNT_W  = $clog2(DIGITS + 1);

  logic                clk = 1'b0;
  logic                clear;
  logic                enablen;
  logic [N_KEYS-1:0]   keypad;
  logic                clr_entry;
  logic [3:0]          D;
  logic [4*DIGITS-1:0] digits;
  logic [CNT_W-1:0]    count;
  logic                loadn;
  logic                full;
  logic                overflow;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int n_load = 0;
  int n_ovf = 0;
  int load_cyc = 0;
  int first_load_cyc = 0;
  int c0 = 0;

  keypad_entry #(
    .N_KEYS          (N_KEYS),
    .DIGITS          (DIGITS),
    .DEBOUNCE_CYCLES (DB),
    .REPEAT_CYCLES   (RPT)
  ) dut (
    .clk       (clk),
    .clear     (clear),
    .enablen   (enablen),
    .keypad    (keypad),
    .clr_entry (clr_entry),
    .D         (D),
    .digits    (digits),
    .count     (count),
    .loadn     (loadn),
    .full      (full),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // One clock edge; observe strobes 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (loadn === 1'b0) begin
      if (n_load == 0) first_load_cyc = cyc;
      n_load++;
      load_cyc = cyc;
    end
    if (overflow === 1'b1) n_ovf++;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clear_stats();
    n_load = 0;
    n_ovf = 0;
    load_cyc = 0;
    first_load_cyc = 0;
  endtask

  task automatic press(input int k, input int hold);
    keypad = '0;
    keypad[k] = 1'b1;
    steps(hold);
    keypad = '0;
    steps(12);
  endtask

  task automatic flush_entry();
    clr_entry = 1'b1;
    step();
    clr_entry = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clear = 1'b1;
    enablen = 1'b0;
    keypad = '0;
    clr_entry = 1'b0;
    steps(3);
    chk("rst_D", 32'(D), 32'h0);
    chk("rst_digits", 32'(digits), 32'h0);
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_loadn", 32'(loadn), 32'h1);
    chk("rst_overflow", 32'(overflow), 32'h0);
    chk("rst_full", 32'(full), 32'h0);
    clear = 1'b0;
    steps(2);

    // Single key, latency from first sampling edge.
    clear_stats();
    c0 = cyc;
    keypad = '0;
    keypad[5] = 1'b1;
    steps(20);
    keypad = '0;
    steps(12);
    chk("k5_nload", 32'(n_load), 32'd1);
    chk("k5_latency", 32'(load_cyc - c0), 32'd8);
    chk("k5_D", 32'(D), 32'h5);
    chk("k5_digits", 32'(digits), 32'h0005);
    chk("k5_count", 32'(count), 32'd1);

    // Fill the buffer then overflow.
    flush_entry();
    chk("clr_count", 32'(count), 32'd0);
    clear_stats();
    for (int k = 1; k <= 4; k++) press(k, 12);
    chk("fill_digits", 32'(digits), 32'h1234);
    chk("fill_full", 32'(full), 32'h1);
    chk("fill_count", 32'(count), 32'd4);
    chk("fill_nload", 32'(n_load), 32'd4);
    chk("fill_D", 32'(D), 32'h4);
    press(5, 12);
    chk("ovf_nload", 32'(n_load), 32'd4);
    chk("ovf_pulses", 32'(n_ovf), 32'd1);
    chk("ovf_digits", 32'(digits), 32'h1234);
    chk("ovf_D", 32'(D), 32'h4);

    // Bounce: high 4, low 1, high 10.
    flush_entry();
    clear_stats();
    keypad = '0;
    keypad[3] = 1'b1;
    steps(4);
    keypad = '0;
    step();
    c0 = cyc;
    keypad[3] = 1'b1;
    steps(10);
    keypad = '0;
    steps(12);
    chk("bnc_nload", 32'(n_load), 32'd1);
    chk("bnc_latency", 32'(load_cyc - c0), 32'd8);
    chk("bnc_D", 32'(D), 32'h3);
    chk("bnc_digits", 32'(digits), 32'h0003);

    // Two keys together: higher index wins.
    clear_stats();
    keypad = '0;
    keypad[2] = 1'b1;
    keypad[8] = 1'b1;
    steps(12);
    keypad = '0;
    steps(12);
    chk("pri_D", 32'(D), 32'h8);
    chk("pri_digits", 32'(digits), 32'h0038);
    chk("pri_nload", 32'(n_load), 32'd1);

    // clr_entry coincident with the acceptance edge discards the key.
    clear_stats();
    keypad = '0;
    keypad[2] = 1'b1;
    keypad[6] = 1'b1;
    steps(DB);
    clr_entry = 1'b1;
    step();
    clr_entry = 1'b0;
    steps(10);
    keypad = '0;
    steps(12);
    chk("clracc_count", 32'(count), 32'd0);
    chk("clracc_digits", 32'(digits), 32'h0);
    chk("clracc_nload", 32'(n_load), 32'd0);
    chk("clracc_D", 32'(D), 32'h8);

    // Held key plus a higher key, partial release: single acceptance.
    clear_stats();
    keypad = '0;
    keypad[1] = 1'b1;
    steps(10);
    keypad[9] = 1'b1;
    steps(10);
    keypad[9] = 1'b0;
    steps(10);
    keypad = '0;
    steps(12);
    chk("hold2_nload", 32'(n_load), 32'd1);
    chk("hold2_D", 32'(D), 32'h1);
    chk("hold2_digits", 32'(digits), 32'h0001);

    // Disabled entry retains state and accepts nothing.
    flush_entry();
    press(6, 12);
    clear_stats();
    enablen = 1'b1;
    press(4, 20);
    chk("dis_nload", 32'(n_load), 32'd0);
    chk("dis_D", 32'(D), 32'h6);
    chk("dis_count", 32'(count), 32'd1);
    chk("dis_digits", 32'(digits), 32'h0006);
    enablen = 1'b0;
    steps(2);

    // clear asserted mid-press.
    clear_stats();
    keypad = '0;
    keypad[7] = 1'b1;
    steps(3);
    clear = 1'b1;
    keypad = '0;
    steps(2);
    chk("clrp_D", 32'(D), 32'h0);
    chk("clrp_count", 32'(count), 32'd0);
    chk("clrp_digits", 32'(digits), 32'h0);
    chk("clrp_loadn", 32'(loadn), 32'h1);
    chk("clrp_full", 32'(full), 32'h0);
    clear = 1'b0;
    steps(12);
    chk("clrp_nload", 32'(n_load), 32'd0);

    // Long hold of key 9.
    clear_stats();
    c0 = cyc;
    keypad = '0;
    keypad[9] = 1'b1;
`ifdef KEYPAD_AUTOREPEAT_EN
    steps(220);
    keypad = '0;
    steps(12);
    chk("rpt_nload", 32'(n_load), 32'd4);
    chk("rpt_first", 32'(first_load_cyc - c0), 32'd8);
    chk("rpt_last", 32'(load_cyc - c0), 32'd158);
    chk("rpt_ovf", 32'(n_ovf), 32'd1);
    chk("rpt_digits", 32'(digits), 32'h9999);
`else
    steps(160);
    keypad = '0;
    steps(12);
    chk("long_nload", 32'(n_load), 32'd1);
    chk("long_latency", 32'(load_cyc - c0), 32'd8);
    chk("long_digits", 32'(digits), 32'h0009);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/keypad_entry.md
KEYPAD_ENTRY -- requirements
Module: keypad_entry

Interface
REQ-001 Parameter N_KEYS, default 10, number of keypad lines; legal range 2..16.
REQ-002 Parameter DIGITS, default 4, depth of the BCD entry buffer; legal range 1..8.
REQ-003 Parameter DEBOUNCE_CYCLES, default 7, consecutive stable cycles required for press and for release; legal range 2..255.
REQ-004 Parameter REPEAT_CYCLES, default 50, auto-repeat interval in clk cycles (used only under KEYPAD_AUTOREPEAT_EN).
REQ-005 clk  input  1  single system clock, all state on rising edge.
REQ-006 clear  input  1  asynchronous, active-high reset.
REQ-007 enablen  input  1  active-low entry enable.
REQ-008 keypad  input  N_KEYS  one line per key, active-high, synchronous to clk (synchronised upstream).
REQ-009 clr_entry  input  1  synchronous clear of the entry buffer.
REQ-010 D  output  4  code of the last accepted key.
REQ-011 digits  output  4*DIGITS  entry buffer; newest digit in [3:0].
REQ-012 count  output  $clog2(DIGITS+1)  number of valid digits in the buffer.
REQ-013 loadn  output  1  active-low one-cycle strobe per accepted key.
REQ-014 full  output  1  high when count == DIGITS.
REQ-015 overflow  output  1  one-cycle high pulse when a key is debounced while full.

Function
REQ-016 Key code: highest-index asserted keypad line wins; code = its index; all-zero keypad = no key.
REQ-017 Debounce FSM states: IDLE, PRESS, HELD, RELEASE.
REQ-018 IDLE -> PRESS when enabled and any key asserted; stability counter loaded with 0 and candidate code captured.
REQ-019 PRESS: counter increments each cycle while code equals candidate; code change or all-zero -> IDLE, no acceptance.
REQ-020 PRESS -> HELD on the edge where counter == DEBOUNCE_CYCLES-1 with code still equal; that edge is the acceptance event.
REQ-021 Acceptance with count < DIGITS: digits shifts left by 4, candidate enters [3:0], count increments, D updates, loadn low for exactly the following cycle.
REQ-022 Acceptance with count == DIGITS: buffer, count, D unchanged, loadn stays high, overflow high for one cycle.
REQ-023 Latency: key stable from first sampling edge E -> loadn low in the cycle after edge E+DEBOUNCE_CYCLES.
REQ-024 HELD: no further acceptance; all-zero keypad -> RELEASE with counter cleared.
REQ-025 RELEASE: any key asserted -> HELD; DEBOUNCE_CYCLES consecutive all-zero cycles -> IDLE.
REQ-026 Held key with a second higher-index key pressed is not accepted until full release.
REQ-027 enablen high: FSM forced to IDLE next edge, no acceptance; digits, count, D retained.
REQ-028 clr_entry: digits and count cleared next edge; wins over a simultaneous acceptance (that key discarded, loadn stays high); FSM state unaffected.
REQ-029 full is combinational from count; count saturates at DIGITS, never wraps.

Reset
REQ-030 clear high: state IDLE, counters 0, digits 0, count 0, D 0, loadn 1, overflow 0, full 0, asynchronously.
REQ-031 clear mid-press aborts the press; no loadn pulse is produced after release of clear for that press unless it is re-debounced from IDLE.

Configuration
REQ-032 Macro KEYPAD_AUTOREPEAT_EN defined: in HELD, after REPEAT_CYCLES continuous cycles of the same code, an acceptance event occurs, then every REPEAT_CYCLES thereafter until release.
REQ-033 Macro KEYPAD_AUTOREPEAT_EN undefined: exactly one acceptance per press; repeat counter and REPEAT_CYCLES logic absent.

Structure
REQ-034 Package keypad_pkg holds the FSM state enum, the code width constant (4) and the no-key code constant.
REQ-035 Sub-module keypad_debounce implements priority encode plus FSM and emits a one-cycle accept pulse with code; keypad_entry owns buffer, count, strobes.

Verification
REQ-036 Defaults; keypad[5] held 20 cycles from edge E -> loadn low in cycle after E+7, D=5, digits=0x0005, count=1.
REQ-037 Keys 1,2,3,4,5 pressed/released in turn -> digits=0x1234, full=1, fifth press gives overflow pulse, no loadn.
REQ-038 keypad[3] bounces (high 4 cycles, low 1, high 10) -> exactly one acceptance, 7 cycles after last rising edge.
REQ-039 keypad[2] and keypad[8] together -> D=8; clr_entry on the acceptance edge -> count=0, loadn never low.
REQ-040 clear asserted during PRESS, enablen high during press -> no acceptance, outputs at reset values.
REQ-041 With KEYPAD_AUTOREPEAT_EN, REPEAT_CYCLES=50, keypad[9] held 160 cycles -> loadn pulses at 7, 57, 107, 157 cycles after first sample (4 pulses, then overflow pulses once full).
